// File: rtl/cache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cache_pkg
// Description : Shared types and default sizes for the cache_dados data cache.
// Revision    : 1.0 - initial release
// ============================================================================
package cache_pkg;

    localparam int c_ADDR_W    = 12;
    localparam int c_DATA_W    = 32;
    localparam int c_NUM_LINES = 16;

    // Controller states, explicitly encoded on two bits
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/cache_linha_array.sv
`default_nettype none
// ============================================================================
// Module      : cache_linha_array
// Description : NUM_LINES x (valid, tag, data) line storage. One combinational
//               read port, one synchronous write port; valid bits cleared by
//               the asynchronous active-low reset.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_linha_array
    import cache_pkg::*;
#(
    parameter int ADDR_W    = c_ADDR_W,
    parameter int DATA_W    = c_DATA_W,
    parameter int NUM_LINES = c_NUM_LINES
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [$clog2(NUM_LINES)-1:0]         rd_idx,
    output logic                                 rd_valid,
    output logic [ADDR_W-$clog2(NUM_LINES)-1:0]  rd_tag,
    output logic [DATA_W-1:0]                    rd_data,
    input  logic                                 wr_en,
    input  logic [$clog2(NUM_LINES)-1:0]         wr_idx,
    input  logic [ADDR_W-$clog2(NUM_LINES)-1:0]  wr_tag,
    input  logic [DATA_W-1:0]                    wr_data
);

    localparam int c_INDEX_W = $clog2(NUM_LINES);
    localparam int c_TAG_W   = ADDR_W - c_INDEX_W;

    logic [NUM_LINES-1:0] r_valid;
    logic [c_TAG_W-1:0]   r_tag  [NUM_LINES];
    logic [DATA_W-1:0]    r_data [NUM_LINES];

    // Valid bits: the only storage that needs reset, so every line starts invalid
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= '0;
        end else if (wr_en) begin
            r_valid[wr_idx] <= 1'b1;
        end
    end

    // Tag and data payload; contents are meaningless until the valid bit is set
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_tag[wr_idx]  <= wr_tag;
            r_data[wr_idx] <= wr_data;
        end
    end

    assign rd_valid = r_valid[rd_idx];
    assign rd_tag   = r_tag[rd_idx];
    assign rd_data  = r_data[rd_idx];

endmodule
`default_nettype wire

// File: rtl/cache_dados.sv
`default_nettype none
// ============================================================================
// Module      : cache_dados
// Description : Direct-mapped, write-through, write-allocate data cache, one
//               word per line, between the multicycle MIPS core and main
//               data memory. Holds the core in its Memory state via stall.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_dados
    import cache_pkg::*;
#(
    parameter int ADDR_W    = c_ADDR_W,
    parameter int DATA_W    = c_DATA_W,
    parameter int NUM_LINES = c_NUM_LINES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              r_en,
    input  logic              w_en,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data,
    output logic [DATA_W-1:0] saida_cache,
    output logic              stall,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_rd,
    output logic              mem_wr,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [15:0]       miss_count
);

    localparam int          c_INDEX_W  = $clog2(NUM_LINES);
    localparam int          c_TAG_W    = ADDR_W - c_INDEX_W;
    localparam logic [15:0] c_MISS_MAX = 16'hFFFF;

    state_t              r_state;
    state_t              w_next_state;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic                r_mem_rd;
    logic                r_mem_wr;
    logic [DATA_W-1:0]   r_saida;
    logic [15:0]         r_miss_count;

    logic                w_stall;
    logic                w_line_valid;
    logic [c_TAG_W-1:0]  w_line_tag;
    logic [DATA_W-1:0]   w_line_data;
    logic                w_hit;
    logic                w_accept_wr;
    logic                w_read_hit;
    logic                w_read_miss;
    logic                w_fill_done;
    logic                w_write_done;
    logic                w_lw_en;
    logic [ADDR_W-1:0]   w_lw_addr;
    logic [DATA_W-1:0]   w_lw_data;

    // Request decode; write wins when both strobes are raised
    assign w_hit        = w_line_valid && (w_line_tag == address[ADDR_W-1:c_INDEX_W]);
    assign w_accept_wr  = (r_state == IDLE) && w_en;
    assign w_read_hit   = (r_state == IDLE) && r_en && !w_en && w_hit;
    assign w_read_miss  = (r_state == IDLE) && r_en && !w_en && !w_hit;
    assign w_fill_done  = (r_state == FILL)  && mem_ready;
    assign w_write_done = (r_state == WRITE) && mem_ready;

    // Line update: write-allocate at acceptance, or refill when memory answers
    assign w_lw_en   = w_accept_wr || w_fill_done;
    assign w_lw_addr = w_accept_wr ? address : r_mem_addr;
    assign w_lw_data = w_accept_wr ? data    : mem_rdata;

    cache_linha_array #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .NUM_LINES (NUM_LINES)
    ) u_linhas (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (address[c_INDEX_W-1:0]),
        .rd_valid (w_line_valid),
        .rd_tag   (w_line_tag),
        .rd_data  (w_line_data),
        .wr_en    (w_lw_en),
        .wr_idx   (w_lw_addr[c_INDEX_W-1:0]),
        .wr_tag   (w_lw_addr[ADDR_W-1:c_INDEX_W]),
        .wr_data  (w_lw_data)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next state and combinational stall
    always_comb begin
        w_next_state = r_state;
        w_stall      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_en) begin
                    w_next_state = WRITE;
                    w_stall      = 1'b1;
                end else if (r_en && !w_hit) begin
                    w_next_state = FILL;
                    w_stall      = 1'b1;
                end
            end
            FILL, WRITE: begin
                w_stall = 1'b1;
                if (mem_ready) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Memory strobes, request latch and read-data register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_rd    <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_saida     <= '0;
        end else begin
            if (w_accept_wr) begin
                r_mem_wr    <= 1'b1;
                r_mem_addr  <= address;
                r_mem_wdata <= data;
            end
            if (w_read_miss) begin
                r_mem_rd   <= 1'b1;
                r_mem_addr <= address;
            end
            if (w_read_hit) begin
                r_saida <= w_line_data;
            end
            if (w_fill_done) begin
                r_mem_rd <= 1'b0;
                r_saida  <= mem_rdata;
            end
            if (w_write_done) begin
                r_mem_wr <= 1'b0;
            end
        end
    end

    // Saturating read-miss counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_miss_count <= '0;
        end else if (w_read_miss && (r_miss_count != c_MISS_MAX)) begin
            r_miss_count <= r_miss_count + 16'd1;
        end
    end

    // A hit is served in the request cycle; otherwise the last value is held
    assign saida_cache = w_read_hit ? w_line_data : r_saida;
    assign stall       = w_stall;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign mem_rd      = r_mem_rd;
    assign mem_wr      = r_mem_wr;
    assign miss_count  = r_miss_count;

endmodule
`default_nettype wire

// File: tb/tb_cache_dados.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_dados
// Description : Self-checking bench for cache_dados: directed scenarios plus
//               random reads/writes against a line-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_dados;

    logic        clk = 1'b0;
    logic        rst;
    logic        r_en;
    logic        w_en;
    logic [11:0] address;
    logic [31:0] data;
    logic [31:0] saida_cache;
    logic        stall;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic [15:0] miss_count;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: backing memory, cache lines and visible CPU-side state
    logic [31:0] ref_mem   [0:4095];
    bit          ref_valid [0:15];
    logic [7:0]  ref_tag   [0:15];
    logic [31:0] ref_data  [0:15];
    logic [31:0] ref_saida;
    int          ref_miss;

    always #5 clk = ~clk;

    cache_dados #(
        .ADDR_W    (12),
        .DATA_W    (32),
        .NUM_LINES (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .r_en        (r_en),
        .w_en        (w_en),
        .address     (address),
        .data        (data),
        .saida_cache (saida_cache),
        .stall       (stall),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rd      (mem_rd),
        .mem_wr      (mem_wr),
        .mem_rdata   (mem_rdata),
        .mem_ready   (mem_ready),
        .miss_count  (miss_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) ref_valid[i] = 1'b0;
        ref_saida = 32'h0;
        ref_miss  = 0;
    endtask

    // One CPU access; memory answers with mem_ready on the lat-th busy cycle
    task automatic access(input bit rd, input bit wr, input logic [11:0] a,
                          input logic [31:0] d, input int lat);
        int   idx = int'(a[3:0]);
        bit   hit = ref_valid[idx] && (ref_tag[idx] == a[11:4]);
        int   stall_cycles = 0;
        r_en    = rd;
        w_en    = wr;
        address = a;
        data    = d;
        if (!wr && hit) begin
            @(negedge clk);
            check("hit_stall", stall, 0);
            check("hit_data", saida_cache, ref_data[idx]);
            check("hit_no_mem_rd", mem_rd, 0);
            check("hit_miss_count", miss_count, ref_miss);
            ref_saida = ref_data[idx];
            @(posedge clk); #1;
            r_en = 1'b0;
            @(negedge clk);
            check("idle_hold", saida_cache, ref_saida);
            @(posedge clk); #1;
            return;
        end
        @(negedge clk);
        if (stall) stall_cycles++;
        check("req_stall", stall, 1);
        @(posedge clk); #1;
        if (wr) begin
            ref_valid[idx] = 1'b1;
            ref_tag[idx]   = a[11:4];
            ref_data[idx]  = d;
            ref_mem[a]     = d;
        end else begin
            ref_miss = (ref_miss < 65535) ? ref_miss + 1 : ref_miss;
        end
        for (int k = 1; k <= lat; k++) begin
            mem_ready = (k == lat);
            mem_rdata = (k == lat && !wr) ? ref_mem[a] : $urandom;
            @(negedge clk);
            if (stall) stall_cycles++;
            check("busy_stall", stall, 1);
            check("busy_mem_rd", mem_rd, !wr);
            check("busy_mem_wr", mem_wr, wr);
            check("busy_mem_addr", mem_addr, a);
            if (wr) check("busy_mem_wdata", mem_wdata, d);
            @(posedge clk); #1;
        end
        mem_ready = 1'b0;
        mem_rdata = $urandom;
        if (!wr) begin
            ref_valid[idx] = 1'b1;
            ref_tag[idx]   = a[11:4];
            ref_data[idx]  = ref_mem[a];
            ref_saida      = ref_mem[a];
        end
        @(negedge clk);
        check("done_stall", stall, 0);
        check("done_saida", saida_cache, ref_saida);
        check("done_mem_rd", mem_rd, 0);
        check("done_mem_wr", mem_wr, 0);
        check("stall_cycles", stall_cycles, lat + 1);
        check("miss_count", miss_count, ref_miss);
        @(posedge clk); #1;
        r_en = 1'b0;
        w_en = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst       = 1'b0;
        r_en      = 1'b0;
        w_en      = 1'b0;
        address   = '0;
        data      = '0;
        mem_rdata = '0;
        mem_ready = 1'b0;
        for (int i = 0; i < 4096; i++) ref_mem[i] = $urandom;
        ref_mem[12'h005] = 32'hDEADBEEF;
        model_reset();

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_saida", saida_cache, 0);
        check("rst_stall", stall, 0);
        check("rst_mem_rd", mem_rd, 0);
        check("rst_mem_wr", mem_wr, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_miss_count", miss_count, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // Cold miss with 3-cycle memory, then hit on the same word
        access(1'b1, 1'b0, 12'h005, 32'h0, 3);
        access(1'b1, 1'b0, 12'h005, 32'h0, 1);
        check("dir_deadbeef", ref_saida, saida_cache);

        // Write-allocate then read hit without any memory read
        access(1'b0, 1'b1, 12'h013, 32'h00000007, 2);
        access(1'b1, 1'b0, 12'h013, 32'h0, 1);

        // Conflict on index 3
        access(1'b1, 1'b0, 12'h003, 32'h0, 2);
        access(1'b1, 1'b0, 12'h013, 32'h0, 1);
        access(1'b1, 1'b0, 12'h003, 32'h0, 4);
        check("dir_conflict_misses", miss_count, 4);

        // Both strobes high: write path
        access(1'b1, 1'b1, 12'h020, 32'hA5A5_0020, 2);

        // Spurious mem_ready while idle
        address   = 12'h005;
        mem_rdata = 32'hBADC0DE5;
        mem_ready = 1'b1;
        @(negedge clk);
        check("spur_stall", stall, 0);
        check("spur_mem_rd", mem_rd, 0);
        check("spur_mem_wr", mem_wr, 0);
        @(posedge clk); #1;
        mem_ready = 1'b0;
        @(negedge clk);
        check("spur_stall2", stall, 0);
        check("spur_saida", saida_cache, ref_saida);
        @(posedge clk); #1;
        access(1'b1, 1'b0, 12'h005, 32'h0, 1);

        // Random traffic over a small address window to force hits and conflicts
        for (int n = 0; n < 300; n++) begin
            int          op;
            logic [11:0] ra;
            op = $urandom_range(0, 9);
            ra = 12'($urandom_range(0, 47));
            if (op < 6)
                access(1'b1, 1'b0, ra, 32'h0, $urandom_range(1, 4));
            else if (op < 9)
                access(1'b0, 1'b1, ra, $urandom, $urandom_range(1, 4));
            else
                access(1'b1, 1'b1, ra, $urandom, $urandom_range(1, 4));
        end

        // Reset in the middle of a refill
        r_en    = 1'b1;
        address = 12'hFF0;
        @(posedge clk); #1;
        @(negedge clk);
        check("midfill_mem_rd", mem_rd, 1);
        #2;
        rst  = 1'b0;
        r_en = 1'b0;
        #1;
        check("arst_stall", stall, 0);
        check("arst_mem_rd", mem_rd, 0);
        check("arst_mem_wr", mem_wr, 0);
        check("arst_miss_count", miss_count, 0);
        check("arst_saida", saida_cache, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        model_reset();
        access(1'b1, 1'b0, 12'h005, 32'h0, 2);
        access(1'b1, 1'b0, 12'h005, 32'h0, 1);
        check("post_rst_miss_count", miss_count, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
